// File: rtl/spi_paddle_tx_if.sv
// Word handshake between a paddle-word producer and spi_paddle_tx.
// repeat_en travels with the handshake because it qualifies what happens when no word is offered.
interface spi_paddle_tx_if #(
  parameter int unsigned DATA_BITS = 9
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 repeat_en;

  modport master (
    output tx_data,
    output tx_valid,
    output repeat_en,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  repeat_en,
    output tx_ready
  );
endinterface

// File: rtl/spi_paddle_tx.sv
// SPI mode-0 transmitter for paddle-position words: MSB first, framed by ss_n, with SCLK phases
// stretched to CLK_DIV clk cycles so a synchronised receiver sees every edge.
module spi_paddle_tx #(
  parameter int unsigned DATA_BITS = 9,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP       = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  spi_paddle_tx_if.slave tx_io,
  output logic           spi_sclk_o,
  output logic           spi_mosi_o,
  output logic           spi_ss_n_o,
  output logic           done_o
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [7:0]      DivLoad = 8'(CLK_DIV - 1);
  localparam logic [7:0]      GapLoad = 8'(GAP - 1);
  localparam logic [IdxW-1:0] IdxLoad = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StTrail,
    StGap
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] last_q, last_d;
  logic                 armed_q, armed_d;

  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic ss_n_q, ss_n_d;
  logic done_q, done_d;
  logic ready_q, ready_d;

  logic phase_end;
  logic accept;
  logic in_frame_d;

  assign phase_end = (cnt_q == 8'd0);
  assign accept    = tx_io.tx_valid & ready_q;

  // Next-state logic: every phase reloads the divider on entry and ends when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    last_d  = last_q;
    armed_d = armed_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = tx_io.tx_data;
          last_d  = tx_io.tx_data;
          armed_d = 1'b1;
          idx_d   = IdxLoad;
          cnt_d   = DivLoad;
          state_d = StShiftLo;
        end else if (tx_io.repeat_en && armed_q) begin
          shift_d = last_q;
          idx_d   = IdxLoad;
          cnt_d   = DivLoad;
          state_d = StShiftLo;
        end
      end

      StShiftLo: begin
        if (phase_end) begin
          cnt_d   = DivLoad;
          state_d = StShiftHi;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StShiftHi: begin
        if (phase_end) begin
          cnt_d = DivLoad;
          if (idx_q == '0) begin
            state_d = StTrail;
          end else begin
            // The next bit moves into the MSB so mosi always comes from one fixed position.
            idx_d   = idx_q - IdxW'(1);
            shift_d = shift_q << 1;
            state_d = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StTrail: begin
        if (phase_end) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StGap: begin
        if (phase_end) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so that every pin comes straight from a flop.
  always_comb begin
    in_frame_d = (state_d == StShiftLo) || (state_d == StShiftHi) || (state_d == StTrail);
    ss_n_d     = ~in_frame_d;
    sclk_d     = (state_d == StShiftHi);
    mosi_d     = in_frame_d ? shift_d[DATA_BITS-1] : 1'b0;
    done_d     = (state_q == StTrail) && (state_d == StGap);
    ready_d    = (state_d == StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      shift_q <= '0;
      last_q  <= '0;
      armed_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign spi_sclk_o     = sclk_q;
  assign spi_mosi_o     = mosi_q;
  assign spi_ss_n_o     = ss_n_q;
  assign done_o         = done_q;
  assign tx_io.tx_ready = ready_q;

endmodule

// File: tb/tb_spi_paddle_tx.sv
// Bench for spi_paddle_tx: a frame-timing model predicts every output cycle, and a scoreboard
// compares the words reassembled from the SPI pins against the words the model expects.
module tb_spi_paddle_tx;

  localparam int N     = 9;
  localparam int D     = 2;
  localparam int G     = 4;
  localparam int SsLen = (2 * N + 1) * D;
  localparam int P     = 2 * N * D + D + G + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic sclk, mosi, ss_n, done;
  spi_paddle_tx_if #(.DATA_BITS(N)) tx_if ();

  spi_paddle_tx #(.DATA_BITS(N), .CLK_DIV(D), .GAP(G)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .tx_io     (tx_if),
    .spi_sclk_o(sclk),
    .spi_mosi_o(mosi),
    .spi_ss_n_o(ss_n),
    .done_o    (done)
  );

  logic rst2;
  logic sclk2, mosi2, ss_n2, done2;
  spi_paddle_tx_if #(.DATA_BITS(N)) tx2_if ();

  spi_paddle_tx #(.DATA_BITS(N), .CLK_DIV(255), .GAP(8)) dut255 (
    .clk_i     (clk),
    .reset_i   (rst2),
    .tx_io     (tx2_if),
    .spi_sclk_o(sclk2),
    .spi_mosi_o(mosi2),
    .spi_ss_n_o(ss_n2),
    .done_o    (done2)
  );

  int checks   = 0;
  int failures = 0;

  int           edge_n  = -1;
  int           start_e = 0;
  bit           active  = 1'b0;
  bit           armed   = 1'b0;
  bit           rst_edge = 1'b0;
  logic [N-1:0] cur_word  = '0;
  logic [N-1:0] last_word = '0;
  logic [N-1:0] sb_q[$];
  logic [N-1:0] last_rx = '0;
  bit           fin255  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // A word can be taken at edge e once a full frame period has elapsed since the last start.
  function automatic bit model_ready(input int e);
    return !active || ((e - start_e) >= P);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    rst_edge = reset;
    if (reset) begin
      active    = 1'b0;
      armed     = 1'b0;
      last_word = '0;
      sb_q.delete();
    end else if (model_ready(edge_n)) begin
      if (tx_if.tx_valid) begin
        cur_word  = tx_if.tx_data;
        last_word = tx_if.tx_data;
        armed     = 1'b1;
        active    = 1'b1;
        start_e   = edge_n;
        sb_q.push_back(cur_word);
      end else if (tx_if.repeat_en && armed) begin
        cur_word = last_word;
        active   = 1'b1;
        start_e  = edge_n;
        sb_q.push_back(cur_word);
      end
    end
  end

  always @(negedge clk) begin : mon
    int           t;
    int           bi;
    bit           e_ss_n, e_sclk, e_mosi, e_done, e_rdy;
    logic [N-1:0] w;
    logic [N-1:0] rx_sh;
    int           nbits;
    logic         prev_sclk;
    logic         prev_ss_n;
    if (edge_n < 0) begin
      nbits     = 0;
      rx_sh     = '0;
      prev_sclk = 1'b0;
      prev_ss_n = 1'b1;
    end else begin
      t      = edge_n - start_e + 1;
      e_ss_n = !(active && t <= SsLen);
      e_sclk = active && (t <= 2 * N * D) && ((((t - 1) / D) % 2) == 1);
      bi     = (t <= 2 * N * D) ? (N - 1 - (t - 1) / (2 * D)) : 0;
      e_mosi = !e_ss_n && cur_word[bi];
      e_done = active && (t == SsLen + 1);
      e_rdy  = !active || (t >= P);
      check("tx_ready", tx_if.tx_ready, e_rdy);
      check("ss_n", ss_n, e_ss_n);
      check("sclk", sclk, e_sclk);
      check("mosi", mosi, e_mosi);
      check("done", done, e_done);

      if (rst_edge) begin
        nbits = 0;
      end else begin
        if (!ss_n && sclk && !prev_sclk) begin
          rx_sh = {rx_sh[N-2:0], mosi};
          nbits++;
        end
        if (ss_n && !prev_ss_n) begin
          if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'(rx_sh), 32'hFFFF_FFFF);
          end else begin
            w = sb_q.pop_front();
            check("frame_word", rx_sh, w);
            check("frame_bits", nbits, N);
          end
          last_rx = rx_sh;
          nbits   = 0;
        end
      end
      prev_sclk = sclk;
      prev_ss_n = ss_n;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!model_ready(edge_n + 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_ready_timeout", n, 0);
  endtask

  task automatic send_one(input logic [N-1:0] d);
    wait_ready();
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = N'($urandom);
  endtask

  initial begin
    reset           = 1'b1;
    tx_if.tx_valid  = 1'b0;
    tx_if.tx_data   = '0;
    tx_if.repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send_one(9'h1A5);
    repeat (50) @(negedge clk);
    check("directed_1a5", last_rx, 9'h1A5);

    // Held valid with data scrambled every cycle: only accept-edge values may appear.
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 5 * P; i++) begin
      tx_if.tx_data = N'($urandom);
      @(negedge clk);
    end
    tx_if.tx_valid = 1'b0;

    send_one(9'h0F0);
    tx_if.repeat_en = 1'b1;
    repeat (3 * P + 10) @(negedge clk);
    check("repeat_0f0", last_rx, 9'h0F0);
    send_one(9'h003);
    repeat (45) @(negedge clk);
    check("repeat_switch_003", last_rx, 9'h003);

    send_one(N'($urandom));
    repeat (18) @(negedge clk);
    check("fifth_hi_sclk", sclk, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ss_n", ss_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ready", tx_if.tx_ready, 1'b1);
    check("rst_done", done, 1'b0);
    repeat (100) @(negedge clk);
    tx_if.repeat_en = 1'b0;
    send_one(N'($urandom));

    for (int i = 0; i < 1500; i++) begin
      tx_if.tx_valid = ($urandom_range(3) == 0);
      tx_if.tx_data  = N'($urandom);
      if ((i % 60) == 0) tx_if.repeat_en = ($urandom_range(2) == 0);
      reset = ($urandom_range(399) == 0);
      @(negedge clk);
    end
    reset           = 1'b0;
    tx_if.tx_valid  = 1'b0;
    tx_if.repeat_en = 1'b0;
    repeat (2 * P) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    for (int i = 0; i < 10000 && !fin255; i++) @(negedge clk);
    check("div255_finished", fin255, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Widest divider: every SCLK phase inside the frame must last exactly 255 clk cycles.
  initial begin : div255
    int           run;
    int           hi_n;
    bit           in_frame;
    logic         ps;
    logic [N-1:0] rx;
    run              = 0;
    hi_n             = 0;
    in_frame         = 1'b0;
    ps               = 1'b0;
    rx               = '0;
    rst2             = 1'b1;
    tx2_if.tx_valid  = 1'b0;
    tx2_if.repeat_en = 1'b0;
    tx2_if.tx_data   = '0;
    repeat (2) @(negedge clk);
    rst2            = 1'b0;
    tx2_if.tx_data  = 9'h155;
    tx2_if.tx_valid = 1'b1;
    @(negedge clk);
    tx2_if.tx_valid = 1'b0;
    for (int i = 0; i < 6000 && !fin255; i++) begin
      if (!ss_n2) begin
        if (in_frame && (sclk2 != ps)) begin
          check("div255_phase", run, 255);
          if (sclk2) begin
            hi_n++;
            rx = {rx[N-2:0], mosi2};
          end
          run = 0;
        end
        in_frame = 1'b1;
        ps       = sclk2;
        run++;
      end else if (in_frame) begin
        check("div255_trail", run, 255);
        fin255 = 1'b1;
      end
      if (!fin255) @(negedge clk);
    end
    check("div255_rises", hi_n, N);
    check("div255_word", rx, 9'h155);
    fin255 = 1'b1;
  end

endmodule

// File: doc/spi_paddle_tx.md
# spi_paddle_tx

SPI-mode-0 transmitter that serialises paddle-position words, MSB first, into the 3-wire link (`spi_sclk`, `spi_mosi`, `spi_ss_n`) read by the game's SPI input stage. It sits on the controller side, e.g. in a test harness or companion tile on the same 25 MHz clock. It accepts a word through a valid/ready handshake and frames it with ss_n. SCLK edges are spaced widely enough to survive the receiver's 3-flop synchroniser and rising-edge detector.

## Interface
- `DATA_BITS`, default 9: bits per frame; matches the receiver's 9-bit paddle frame.
- `CLK_DIV`, default 4: clk cycles per SCLK half-period; legal range 2..255.
- `GAP`, default 8: clk cycles ss_n is held high between frames; legal range 2..255.

- `clk` input 1: system clock; the same 25 MHz domain as the game.
- `reset` input 1: synchronous, active-high reset.
- `tx_data` input DATA_BITS: word to send; sampled only on accept.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_ready` output 1: block can accept a word; accept = `tx_valid & tx_ready` at a clk edge.
- `repeat_en` input 1: when high and no new word is offered at IDLE, re-send the last accepted word.
- `spi_sclk` output 1: serial clock; idles low (CPOL=0).
- `spi_mosi` output 1: serial data; changes only while SCLK is low.
- `spi_ss_n` output 1: frame select, active low.
- `done` output 1: one-cycle pulse at the end of each frame.

## Operation
- All outputs are registered. Reset values: `spi_ss_n`=1, `spi_sclk`=0, `spi_mosi`=0, `done`=0, `tx_ready`=1; state=IDLE; shift register and last-word register cleared to 0.
- Reset while `reset` is high overrides everything; `tx_valid` is ignored during reset.
- States: IDLE -> SHIFT_LO <-> SHIFT_HI -> TRAIL -> GAP -> IDLE.
- **IDLE.** `tx_ready`=1.
  - On accept: latch `tx_data` into the shift register and into the last-word register, then go to SHIFT_LO with bit index = DATA_BITS-1.
  - Else if `repeat_en`=1 and at least one word has been accepted since reset: reload the last word and go to SHIFT_LO. `tx_ready` drops in the same way as for an accept.
- **SHIFT_LO.** `ss_n`=0, `sclk`=0, `mosi`=current bit. Lasts CLK_DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI.** `sclk`=1 and `mosi` is held. Lasts CLK_DIV cycles.
  - If this is the last bit (index 0), go to TRAIL.
  - Otherwise decrement the index and return to SHIFT_LO.
- **TRAIL.** `ss_n`=0, `sclk`=0, `mosi` held. Lasts CLK_DIV cycles, then go to GAP.
- **GAP.** `ss_n`=1, `sclk`=0, `mosi`=0. Lasts GAP cycles, then go to IDLE. `done`=1 in the first GAP cycle only.
- The divider counter is 8 bits and reloads to CLK_DIV-1 on every phase entry. The bit index is ceil(log2(DATA_BITS)) bits wide.
- A new `tx_valid` during a frame is not accepted. `tx_data` changes mid-frame have no effect.
- An explicit accept in IDLE takes priority over a repeat.
- Reset mid-frame: next cycle `ss_n`=1 and `sclk`=0. The receiver discards the partial frame because its bit counter clears while ss is inactive. Repeat is disarmed until the next accept.

## Timing
- Accept at edge 0 produces the following sequence:
  - Cycle 1: `ss_n`=0, `mosi`=`tx_data[DATA_BITS-1]`, `tx_ready`=0.
  - SCLK rising edges at cycles 1+CLK_DIV+2k·CLK_DIV, for k = 0..DATA_BITS-1.
  - `ss_n` rises at cycle 1+(2·DATA_BITS+1)·CLK_DIV.
  - `tx_ready`=1 again at cycle 1+(2·DATA_BITS+1)·CLK_DIV+GAP.
- Frame period, accept to next possible accept: 2·DATA_BITS·CLK_DIV + CLK_DIV + GAP + 1 cycles. With defaults this is 72+4+8+1 = 85.
- MOSI setup before each SCLK rise = CLK_DIV cycles; hold after the rise = CLK_DIV cycles. Both are ≥2, which the receiver's 2-stage synchroniser requires.
- Back-to-back accepts are sustained when `tx_valid` is held high. Zero-cycle gap beyond GAP is allowed in IDLE: accept occurs in the first IDLE cycle.

## Test plan
- Reset, then `tx_data`=9'h1A5 with `tx_valid` for 1 cycle, CLK_DIV=2, GAP=4:
  - `ss_n` low on cycles 1..38.
  - SCLK rises at 3,7,...,35.
  - Bits sampled at the rises: 1,1,0,1,0,0,1,0,1.
  - `done` at cycle 39; `tx_ready`=1 at cycle 43.
- Loopback into the game's SPI receiver stage, sending 9'd64 then 9'd300 back-to-back:
  - The receiver's 9-bit buffer holds 64 after frame 1 and 300 after frame 2.
  - Its bit counter returns to 0 after each frame.
- `tx_valid` held high while `tx_data` is toggled mid-frame:
  - Only the value present at each accept edge is transmitted.
  - Exactly one frame per 43 cycles with CLK_DIV=2, GAP=4.
- `repeat_en`=1 after one accept of 9'h0F0 and `tx_valid`=0: identical 9'h0F0 frames repeat every 43 cycles. Asserting `tx_valid` with 9'h003 switches the next frame to 9'h003.
- `reset` asserted during the 5th SHIFT_HI:
  - Next cycle `ss_n`=1, `sclk`=0, `mosi`=0, `tx_ready`=1, `done`=0.
  - No repeat occurs with `repeat_en`=1 until a new accept.
- CLK_DIV=255, DATA_BITS=9: SCLK high and low phases each measure exactly 255 cycles, with no divider overflow.
